// File: rtl/lifo_stack_if.sv
// lifo_stack_if: push/pop request and status bundle for lifo_stack.
// The hwm signal exists only when LIFO_STACK_WATERMARK_EN is defined.
interface lifo_stack_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic             pop_valid;
   logic [WIDTH-1:0] top;
   logic [CNT_W-1:0] count;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;
`ifdef LIFO_STACK_WATERMARK_EN
   logic [CNT_W-1:0] hwm;
`endif
   modport master (
      output push, pop, din,
      input  dout, pop_valid, top, count, empty, full, overflow, underflow
`ifdef LIFO_STACK_WATERMARK_EN
      , input hwm
`endif
   );
   modport slave (
      input  push, pop, din,
      output dout, pop_valid, top, count, empty, full, overflow, underflow
`ifdef LIFO_STACK_WATERMARK_EN
      , output hwm
`endif
   );
endinterface

// File: rtl/lifo_stack.sv
// lifo_stack: parametrised LIFO with replace-top/bypass, status and error pulses.
// Define LIFO_STACK_WATERMARK_EN to add the hwm (max count since reset) output.
module lifo_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input logic       clk,
   input logic       reset,
   lifo_stack_if.slave s
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int AW    = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [CNT_W-1:0] count, count_nxt;
   logic [WIDTH-1:0] dout;
   logic             pop_valid, overflow, underflow;
   logic             empty, full, do_push, do_pop, do_repl;
   logic [AW-1:0]    top_idx, wr_idx;
   assign empty   = count == '0;
   assign full    = count == CNT_W'(DEPTH);
   assign top_idx = AW'(count - 1'b1);
   assign wr_idx  = AW'(count);
   assign do_push = s.push && !s.pop && !full;
   assign do_pop  = s.pop && !s.push && !empty;
   assign do_repl = s.push && s.pop && !empty;
   assign count_nxt = do_push ? count + 1'b1 : do_pop ? count - 1'b1 : count;
   // storage is deliberately left uncleared by reset
   always_ff @(posedge clk)
      if (!reset && (do_push || do_repl))
         mem[do_repl ? top_idx : wr_idx] <= s.din;
   always_ff @(posedge clk)
      if (reset) begin
         count     <= '0;
         dout      <= '0;
         pop_valid <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         count     <= count_nxt;
         pop_valid <= s.pop && (s.push || !empty);
         overflow  <= s.push && !s.pop && full;
         underflow <= s.pop && !s.push && empty;
         if (s.pop && !empty)
            dout <= mem[top_idx];
         else if (s.pop && s.push)
            dout <= s.din;
      end
`ifdef LIFO_STACK_WATERMARK_EN
   logic [CNT_W-1:0] hwm;
   always_ff @(posedge clk)
      if (reset)
         hwm <= '0;
      else
         hwm <= count_nxt > hwm ? count_nxt : hwm;
   assign s.hwm = hwm;
`endif
   assign s.top       = empty ? '0 : mem[top_idx];
   assign s.dout      = dout;
   assign s.pop_valid = pop_valid;
   assign s.count     = count;
   assign s.empty     = empty;
   assign s.full      = full;
   assign s.overflow  = overflow;
   assign s.underflow = underflow;
endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed stimulus with an expected-pop-data queue checked by a
// separate monitor on every pop_valid strobe.
module tb_lifo_stack;
   logic clk = 0;
   logic reset = 1;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] exp_q[$];
   lifo_stack_if #(.WIDTH(8), .DEPTH(8)) bus ();
   lifo_stack #(.WIDTH(8), .DEPTH(8)) dut (.clk(clk), .reset(reset), .s(bus));
   always #5 clk = ~clk;
   always @(negedge clk)
      if (!reset && bus.pop_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_data: unexpected pop_valid, dout=%0h", bus.dout);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (bus.dout !== e) begin
               errors++;
               $display("FAIL pop_data: got %0h expected %0h", bus.dout, e);
            end
         end
      end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic cyc(input logic p, input logic q, input logic [7:0] d,
                      input logic ev, input logic [7:0] e);
      @(negedge clk);
      bus.push = p;
      bus.pop  = q;
      bus.din  = d;
      if (ev) exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask
   task automatic chk_reset_state();
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_dout", 32'(bus.dout), 0);
      chk("rst_pop_valid", 32'(bus.pop_valid), 0);
      chk("rst_overflow", 32'(bus.overflow), 0);
      chk("rst_underflow", 32'(bus.underflow), 0);
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_full", 32'(bus.full), 0);
      chk("rst_top", 32'(bus.top), 0);
`ifdef LIFO_STACK_WATERMARK_EN
      chk("rst_hwm", 32'(bus.hwm), 0);
`endif
   endtask
   initial begin
      bus.push = 0;
      bus.pop  = 0;
      bus.din  = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state();
      @(negedge clk);
      reset = 0;
      cyc(1, 0, 8'h11, 0, 0);
      cyc(1, 0, 8'h22, 0, 0);
      cyc(1, 0, 8'h33, 0, 0);
      chk("push3_count", 32'(bus.count), 3);
      chk("push3_top", 32'(bus.top), 32'h33);
      chk("push3_empty", 32'(bus.empty), 0);
      chk("push3_full", 32'(bus.full), 0);
      cyc(0, 1, 0, 1, 8'h33);
      chk("pop1_valid", 32'(bus.pop_valid), 1);
      chk("pop1_dout", 32'(bus.dout), 32'h33);
      cyc(0, 1, 0, 1, 8'h22);
      cyc(0, 1, 0, 1, 8'h11);
      chk("pop3_dout", 32'(bus.dout), 32'h11);
      chk("pop3_count", 32'(bus.count), 0);
      chk("pop3_empty", 32'(bus.empty), 1);
      chk("pop3_top", 32'(bus.top), 0);
      cyc(0, 1, 0, 0, 0);
      chk("uf_pulse", 32'(bus.underflow), 1);
      chk("uf_pop_valid", 32'(bus.pop_valid), 0);
      chk("uf_dout_hold", 32'(bus.dout), 32'h11);
      chk("uf_no_overflow", 32'(bus.overflow), 0);
      cyc(1, 1, 8'h5C, 1, 8'h5C);
      chk("uf_one_cycle", 32'(bus.underflow), 0);
      chk("bypass_dout", 32'(bus.dout), 32'h5C);
      chk("bypass_valid", 32'(bus.pop_valid), 1);
      chk("bypass_count", 32'(bus.count), 0);
      cyc(0, 0, 0, 0, 0);
      chk("idle_valid", 32'(bus.pop_valid), 0);
      chk("idle_dout_hold", 32'(bus.dout), 32'h5C);
      cyc(1, 0, 8'h11, 0, 0);
      cyc(1, 0, 8'h22, 0, 0);
      chk("pre_repl_top", 32'(bus.top), 32'h22);
      cyc(1, 1, 8'h77, 1, 8'h22);
      chk("repl_dout", 32'(bus.dout), 32'h22);
      chk("repl_valid", 32'(bus.pop_valid), 1);
      chk("repl_top", 32'(bus.top), 32'h77);
      chk("repl_count", 32'(bus.count), 2);
      chk("repl_no_err", 32'({bus.overflow, bus.underflow}), 0);
      cyc(0, 1, 0, 1, 8'h77);
      cyc(0, 1, 0, 1, 8'h11);
      for (int i = 1; i <= 8; i++) cyc(1, 0, 8'(i), 0, 0);
      chk("fill_full", 32'(bus.full), 1);
      chk("fill_count", 32'(bus.count), 8);
      cyc(1, 0, 8'hAA, 0, 0);
      chk("ovf_pulse", 32'(bus.overflow), 1);
      chk("ovf_count", 32'(bus.count), 8);
      chk("ovf_top", 32'(bus.top), 8);
      chk("ovf_no_underflow", 32'(bus.underflow), 0);
      cyc(1, 1, 8'h99, 1, 8'h08);
      chk("ovf_one_cycle", 32'(bus.overflow), 0);
      chk("repl_full_count", 32'(bus.count), 8);
      chk("repl_full_top", 32'(bus.top), 32'h99);
      cyc(0, 1, 0, 1, 8'h99);
      for (int i = 7; i >= 1; i--) cyc(0, 1, 0, 1, 8'(i));
      chk("drain_empty", 32'(bus.empty), 1);
`ifdef LIFO_STACK_WATERMARK_EN
      chk("hwm_full", 32'(bus.hwm), 8);
      @(negedge clk);
      reset = 1;
      @(posedge clk);
      #1;
      @(negedge clk);
      reset = 0;
      for (int i = 1; i <= 5; i++) cyc(1, 0, 8'(i), 0, 0);
      for (int i = 5; i >= 2; i--) cyc(0, 1, 0, 1, 8'(i));
      chk("hwm_5", 32'(bus.hwm), 5);
      chk("hwm_count1", 32'(bus.count), 1);
`endif
      cyc(1, 0, 8'h44, 0, 0);
      @(negedge clk);
      bus.push = 1;
      bus.pop  = 0;
      bus.din  = 8'h66;
      reset    = 1;
      @(posedge clk);
      #1;
      chk_reset_state();
      @(negedge clk);
      reset    = 0;
      bus.push = 0;
      repeat (2) cyc(0, 0, 0, 0, 0);
      chk("queue_drained", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
